// File: rtl/clk_period_meter_if.sv
// Signal bundle between the period meter and the logic that drives and observes it.
// The slave modport is the meter's view; the master modport belongs to whoever drives S_CLK.
interface clk_period_meter_if #(
    parameter int CNT_W = 16
) ();
    logic             S_CLK;
    logic [CNT_W-1:0] O_PERIOD;
    logic [CNT_W-1:0] O_HIGH;
    logic             O_VALID;
    logic             O_TIMEOUT;

    modport master (
        output S_CLK,
        input  O_PERIOD,
        input  O_HIGH,
        input  O_VALID,
        input  O_TIMEOUT
    );

    modport slave (
        input  S_CLK,
        output O_PERIOD,
        output O_HIGH,
        output O_VALID,
        output O_TIMEOUT
    );
endinterface

// File: rtl/clk_period_meter.sv
// Measures the period of a slow clock S_CLK in I_CLK cycles.
// S_CLK is synchronised, its rising edges are detected, and the I_CLK cycles between
// consecutive rises are published on O_PERIOD with a one-cycle O_VALID pulse.
// O_TIMEOUT is raised when no rise has been seen for TIMEOUT_CYC cycles.
// Optional feature macro: DUTY_MEASURE_EN adds high-time measurement on O_HIGH;
// without it O_HIGH is tied to zero and the port list is unchanged.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,     // must be >= 2
    parameter int TIMEOUT_CYC = 50000  // must fit in CNT_W bits
) (
    input  logic                 I_CLK,
    input  logic                 rst,
    clk_period_meter_if.slave    bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEAS = 2'd1;
    localparam logic [1:0] ST_TMO  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_timeout;

    logic w_s_q;
    logic w_rise;
    logic w_report;

    assign w_s_q    = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_s_q & ~r_s_prev;
    assign w_report = (r_state == ST_MEAS) && w_rise;

    // Synchronise the asynchronous S_CLK and keep its previous value for edge detection.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_s_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values,
            // so the shift chain moves exactly one stage per clock.
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.S_CLK};
            r_s_prev <= w_s_q;
        end
    end

    // Cycle counter since the last rise: restarts at 1 on a rise, otherwise saturates upward.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_ONE;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Measurement FSM: arm on the first rise, report on each later rise, flag stalls.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_MEAS;
                    end else if (r_cnt == TMO_VAL) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_TMO;
                    end
                end
                ST_MEAS: begin
                    // A rise landing on the timeout count is a valid period, so it takes priority.
                    if (w_rise) begin
                        r_period <= r_cnt;
                        r_valid  <= 1'b1;
                    end else if (r_cnt == TMO_VAL) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_TMO;
                    end
                end
                ST_TMO: begin
                    // The first rise after a stall only re-arms; its period is meaningless.
                    if (w_rise) begin
                        r_timeout <= 1'b0;
                        r_state   <= ST_MEAS;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.O_PERIOD  = r_period;
    assign bus.O_VALID   = r_valid;
    assign bus.O_TIMEOUT = r_timeout;

`ifdef DUTY_MEASURE_EN
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_hi_hold;
    logic [CNT_W-1:0] r_high;
    logic             w_fall;

    assign w_fall = ~w_s_q & r_s_prev;

    // High-time counter, captured on the falling edge and published with the next report.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            r_hcnt    <= '0;
            r_hi_hold <= '0;
            r_high    <= '0;
        end else begin
            if (w_rise) begin
                r_hcnt <= CNT_ONE;
            end else if (w_s_q && (r_hcnt != CNT_MAX)) begin
                r_hcnt <= r_hcnt + CNT_ONE;
            end
            if (w_fall) begin
                r_hi_hold <= r_hcnt;
            end
            if (w_report) begin
                r_high <= r_hi_hold;
            end
        end
    end

    assign bus.O_HIGH = r_high;
`else
    logic w_unused;
    assign w_unused   = w_report;
    assign bus.O_HIGH = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter.
// S_CLK is driven on the falling edge of I_CLK with whole-cycle high/low phases, so the
// rise-to-rise distance seen by the meter equals high+low. Each rise that closes an armed
// period pushes the expected report into a queue; a monitor pops and compares on O_VALID.
module tb_clk_period_meter;

    localparam int CNT_W = 16;
    localparam int SYNC  = 2;
    localparam int TMO   = 100;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .I_CLK (clk),
        .rst   (rst),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    bit armed       = 1'b0;
    bit tmo_pending = 1'b0;
    int prev_h      = 0;
    int prev_l      = 0;
    int last_period = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int exp_high(input int h);
`ifdef DUTY_MEASURE_EN
        return h;
`else
        return 0;
`endif
    endfunction

    // Report expected when a rise closes an armed period.
    task automatic push_prev();
        exp_t e;
        if (armed) begin
            e.period = CNT_W'(prev_h + prev_l);
            e.high   = CNT_W'(exp_high(prev_h));
            exp_q.push_back(e);
            last_period = prev_h + prev_l;
        end
    endtask

    // One S_CLK cycle: h cycles high then l cycles low, starting at a falling I_CLK edge.
    // Rise detection lands on the posedge SYNC+1 edges after the drive.
    task automatic gen_cycle(input int h, input int l);
        int tot;
        tot = h + l;
        bus.S_CLK = 1'b1;
        push_prev();
        for (int k = 0; k < tot; k++) begin
            if (k == h) bus.S_CLK = 1'b0;
            if (tmo_pending && k == SYNC)
                check("timeout_held_until_rise", bus.O_TIMEOUT, 1);
            if (k == SYNC + 1)
                check("timeout_clear_after_rise", bus.O_TIMEOUT, 0);
            if (tot > TMO && k == TMO + SYNC)
                check("timeout_not_early", bus.O_TIMEOUT, 0);
            if (tot > TMO && k == TMO + SYNC + 1) begin
                check("timeout_set", bus.O_TIMEOUT, 1);
                check("period_kept_on_timeout", bus.O_PERIOD, last_period);
            end
            @(negedge clk);
        end
        tmo_pending = (tot > TMO);
        armed       = (tot <= TMO);
        prev_h      = h;
        prev_l      = l;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_period"},  bus.O_PERIOD,  0);
        check({tag, "_high"},    bus.O_HIGH,    0);
        check({tag, "_valid"},   bus.O_VALID,   0);
        check({tag, "_timeout"}, bus.O_TIMEOUT, 0);
    endtask

    // Monitor: every O_VALID must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.O_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("report_period", bus.O_PERIOD, mon_e.period);
                check("report_high",   bus.O_HIGH,   mon_e.high);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        bus.S_CLK = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 5 high / 5 low: first report at the second rise, then every 10 cycles.
        repeat (6) gen_cycle(5, 5);

        // 3 high / 5 low: period 8, high 3.
        repeat (5) gen_cycle(3, 5);

        // Stall after a 10-cycle period, then restart.
        gen_cycle(5, 5);
        gen_cycle(5, 150);
        repeat (3) gen_cycle(5, 5);

        // Rise exactly on the timeout count reports period TMO, no timeout.
        gen_cycle(5, TMO - 5);
        repeat (2) gen_cycle(5, 5);

        // Asynchronous reset pulse during the low phase, off the clock edge.
        bus.S_CLK = 1'b1;
        push_prev();
        repeat (5) @(negedge clk);
        bus.S_CLK = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #3;
        check_outputs_zero("async_reset");
        rst = 1'b0;
        exp_q.delete();
        armed       = 1'b0;
        tmo_pending = 1'b0;
        last_period = 0;
        @(negedge clk);
        gen_cycle(5, 5);
        check("no_report_after_first_rise", bus.O_PERIOD, 0);
        repeat (2) gen_cycle(5, 5);

        // Fastest input: period 2 every 2 cycles.
        repeat (8) gen_cycle(1, 1);
        gen_cycle(5, 5);

        repeat (10) @(negedge clk);
        check("all_reports_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
